// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: exception codes,
// per-stage stall vectors and FSM state encodings.
package pipe_ctrl_pkg;

  // Exception code reported by MEM for an ERET instruction.
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Stall vectors: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t ST_RUN      = 2'd0;
  localparam ctrl_state_t ST_MC_BUSY  = 2'd1;
  localparam ctrl_state_t ST_EXC_HOLD = 2'd2;
  localparam ctrl_state_t ST_FLUSH    = 2'd3;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the sequencing controller.
// master = pipeline side (raises requests), slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int MC_W = 6
);
  logic            stallreq_id;
  logic            stallreq_mem;
  logic            ex_mc_start;
  logic [MC_W-1:0] ex_mc_len;
  logic [31:0]     excepttype;
  logic [31:0]     cp0_epc;
  logic [5:0]      stall;
  logic            flush;
  logic [31:0]     new_pc;
  logic            ex_mc_done;
  logic            busy;

  modport master (
    output stallreq_id, stallreq_mem, ex_mc_start, ex_mc_len, excepttype, cp0_epc,
    input  stall, flush, new_pc, ex_mc_done, busy
  );

  modport slave (
    input  stallreq_id, stallreq_mem, ex_mc_start, ex_mc_len, excepttype, cp0_epc,
    output stall, flush, new_pc, ex_mc_done, busy
  );
endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle EX down-counter: loads the remaining cycle count on a start,
// decrements while enabled and emits a registered one-cycle done pulse.
// A length of 0 is treated as 1 (done on the next cycle, nothing loaded).
module pipe_ctrl_mc_counter #(
  parameter int MC_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [MC_W-1:0] len,
  input  logic            en,
  input  logic            abort,
  output logic [MC_W-1:0] cnt,
  output logic            done
);
  localparam logic [MC_W-1:0] ONE = MC_W'(1);

  logic [MC_W-1:0] eff_len;

  assign eff_len = (len == '0) ? ONE : len;

  // Abort beats load beats decrement; done fires the cycle after the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= eff_len - ONE;
      done <= (eff_len == ONE);
    end else if ((cnt != '0) && en) begin
      cnt  <= cnt - ONE;
      done <= (cnt == ONE);
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencing controller for the 5-stage core: merges stall
// requests into a per-stage stall vector, sequences multi-cycle EX ops and
// turns a MEM exception/ERET into a one-cycle freeze followed by a flush.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          MC_W       = 6
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam logic [MC_W-1:0] ONE = MC_W'(1);

  ctrl_state_t     state;
  logic [MC_W-1:0] mc_cnt;
  logic            exc_hit;
  logic            mc_load;
  logic            mc_last;
  logic            mc_done;
  logic            flush_q;
  logic [31:0]     new_pc_q;

  // An exception only counts while the pipeline is live; in HOLD/FLUSH it is stale.
  assign exc_hit = (bus.excepttype != 32'h0) &&
                   ((state == ST_RUN) || (state == ST_MC_BUSY));
  assign mc_load = (state == ST_RUN) && bus.ex_mc_start && !exc_hit;
  assign mc_last = !bus.stallreq_mem && (mc_cnt == ONE);

  pipe_ctrl_mc_counter #(.MC_W(MC_W)) u_mc_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (mc_load),
    .len   (bus.ex_mc_len),
    .en    (!bus.stallreq_mem),
    .abort (exc_hit),
    .cnt   (mc_cnt),
    .done  (mc_done)
  );

  // Sequencing FSM: RUN <-> MC_BUSY, and RUN/MC_BUSY -> EXC_HOLD -> FLUSH -> RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_hit)                        state <= ST_EXC_HOLD;
          else if (mc_load && (bus.ex_mc_len > ONE)) state <= ST_MC_BUSY;
        end
        ST_MC_BUSY: begin
          if (exc_hit)      state <= ST_EXC_HOLD;
          else if (mc_last) state <= ST_RUN;
        end
        ST_EXC_HOLD: state <= ST_FLUSH;
        default:     state <= ST_RUN;
      endcase
    end
  end

  // Flush is presented for exactly the FLUSH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_q <= 1'b0;
    else     flush_q <= (state == ST_EXC_HOLD);
  end

  // Redirect target is captured when the exception is accepted and held until the flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          new_pc_q <= 32'h0;
    else if (exc_hit) new_pc_q <= (bus.excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
  end

  // Stall priority: exception freeze, flush release, MEM, EX busy, ID hazard.
  always_comb begin
    bus.stall = STALL_NONE;
    if (exc_hit || (state == ST_EXC_HOLD))               bus.stall = STALL_ALL;
    else if (state == ST_FLUSH)                          bus.stall = STALL_NONE;
    else if (bus.stallreq_mem)                           bus.stall = STALL_MEM;
    else if ((state == ST_MC_BUSY) ||
             ((state == ST_RUN) && bus.ex_mc_start))     bus.stall = STALL_EX;
    else if (bus.stallreq_id)                            bus.stall = STALL_ID;
  end

  assign bus.flush      = flush_q;
  assign bus.new_pc     = new_pc_q;
  assign bus.ex_mc_done = mc_done;
  assign bus.busy       = (state != ST_RUN);
endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: table-driven directed vectors, hand-written
// multi-cycle sequences and a randomized run against a cycle-level model.
module tb_pipe_ctrl;
  localparam logic [31:0] ERET = 32'h0000_000e;
  localparam logic [31:0] EVEC = 32'h0000_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.MC_W(6)) bus ();

  pipe_ctrl #(.EXC_VECTOR(EVEC), .MC_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        id, mem, start;
    logic [5:0]  len;
    logic [31:0] exc, epc;
    logic [5:0]  e_stall;
    logic        e_flush, e_done, e_busy;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic id, mem, start, input logic [5:0] len,
                              input logic [31:0] exc, epc, input logic [5:0] e_stall,
                              input logic e_flush, e_done, e_busy, input logic [31:0] e_pc);
    vec_t v;
    v.id = id; v.mem = mem; v.start = start; v.len = len; v.exc = exc; v.epc = epc;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_done = e_done; v.e_busy = e_busy;
    v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic id, mem, start, input logic [5:0] len,
                        input logic [31:0] exc, epc);
    bus.stallreq_id = id; bus.stallreq_mem = mem; bus.ex_mc_start = start;
    bus.ex_mc_len = len; bus.excepttype = exc; bus.cp0_epc = epc;
  endtask

  // One cycle: drive just after the rising edge, then wait for the falling edge to sample.
  task automatic step(input logic id, mem, start, input logic [5:0] len,
                      input logic [31:0] exc, epc);
    @(posedge clk); #1;
    set_in(id, mem, start, len, exc, epc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 6'd0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int          m_rem, m_phase;
    bit          m_done;
    logic [31:0] m_pc;
    logic        r_id, r_mem, r_st;
    logic [5:0]  r_len;
    logic [31:0] r_exc, r_epc;
    logic [5:0]  x_stall;
    bit          x_live, any_done;
    int          n_len;

    // Priority
    vecs[0]  = mk(1, 1, 0, 6'd0, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000111, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    // len=4 multi-cycle op
    vecs[3]  = mk(0, 0, 1, 6'd4, 32'h0, 32'h0, 6'b001111, 0, 0, 0, 32'h0);
    vecs[4]  = mk(1, 0, 0, 6'd0, 32'h0, 32'h0, 6'b001111, 0, 0, 1, 32'h0);
    vecs[5]  = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b001111, 0, 0, 1, 32'h0);
    vecs[6]  = mk(0, 0, 1, 6'd9, 32'h0, 32'h0, 6'b001111, 0, 0, 1, 32'h0);
    vecs[7]  = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 1, 0, 32'h0);
    // len=0 behaves as len=1
    vecs[8]  = mk(0, 0, 1, 6'd0, 32'h0, 32'h0, 6'b001111, 0, 0, 0, 32'h0);
    vecs[9]  = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 1, 0, 32'h0);
    // Plain exception
    vecs[10] = mk(0, 0, 0, 6'd0, 32'h8, 32'h0, 6'b111111, 0, 0, 0, 32'h0);
    vecs[11] = mk(1, 1, 0, 6'd0, 32'h0, 32'h0, 6'b111111, 0, 0, 1, 32'h0);
    vecs[12] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 1, 0, 1, EVEC);
    vecs[13] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    // ERET, with a stale exception during the flush cycle
    vecs[14] = mk(0, 0, 0, 6'd0, ERET, 32'hBFC0_0100, 6'b111111, 0, 0, 0, 32'h0);
    vecs[15] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b111111, 0, 0, 1, 32'h0);
    vecs[16] = mk(0, 0, 0, 6'd0, 32'h8, 32'h0, 6'b000000, 1, 0, 1, 32'hBFC0_0100);
    vecs[17] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    vecs[18] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    // Start and exception together: exception wins
    vecs[19] = mk(0, 0, 1, 6'd5, 32'h4, 32'h0, 6'b111111, 0, 0, 0, 32'h0);
    vecs[20] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b111111, 0, 0, 1, 32'h0);
    vecs[21] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 1, 0, 1, EVEC);
    vecs[22] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    vecs[23] = mk(0, 0, 0, 6'd0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);

    do_reset();
    @(negedge clk);
    chk("reset stall", 32'(bus.stall), 32'h0);
    chk("reset flush", 32'(bus.flush), 32'h0);
    chk("reset done", 32'(bus.ex_mc_done), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset new_pc", bus.new_pc, 32'h0);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].id, vecs[i].mem, vecs[i].start, vecs[i].len, vecs[i].exc, vecs[i].epc);
      chk($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d flush", i), 32'(bus.flush), 32'(vecs[i].e_flush));
      chk($sformatf("vec%0d done", i), 32'(bus.ex_mc_done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_flush) chk($sformatf("vec%0d new_pc", i), bus.new_pc, vecs[i].e_pc);
    end

    // MEM stall inside a len=3 op: done slips from cycle 3 to cycle 5
    do_reset();
    step(0, 0, 1, 6'd3, 32'h0, 32'h0);
    chk("memmc c0 stall", 32'(bus.stall), 32'h0f);
    step(0, 1, 0, 6'd0, 32'h0, 32'h0);
    chk("memmc c1 stall", 32'(bus.stall), 32'h1f);
    step(0, 1, 0, 6'd0, 32'h0, 32'h0);
    chk("memmc c2 stall", 32'(bus.stall), 32'h1f);
    step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    chk("memmc c3 done", 32'(bus.ex_mc_done), 32'h0);
    step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    chk("memmc c4 stall", 32'(bus.stall), 32'h0f);
    chk("memmc c4 done", 32'(bus.ex_mc_done), 32'h0);
    step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    chk("memmc c5 done", 32'(bus.ex_mc_done), 32'h1);
    chk("memmc c5 stall", 32'(bus.stall), 32'h0);

    // Abort: exception at cycle 2 of a len=8 op
    do_reset();
    any_done = 0;
    step(0, 0, 1, 6'd8, 32'h0, 32'h0);
    step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    any_done |= bus.ex_mc_done;
    step(0, 0, 0, 6'd0, 32'h8, 32'h0);
    chk("abort c2 stall", 32'(bus.stall), 32'h3f);
    step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    any_done |= bus.ex_mc_done;
    step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    chk("abort c4 flush", 32'(bus.flush), 32'h1);
    any_done |= bus.ex_mc_done;
    step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    chk("abort c5 busy", 32'(bus.busy), 32'h0);
    chk("abort c5 flush", 32'(bus.flush), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 6'd0, 32'h0, 32'h0);
      any_done |= bus.ex_mc_done;
    end
    chk("abort no done", 32'(any_done), 32'h0);

    // Reset asserted in cycle 4 of a len=10 op
    do_reset();
    any_done = 0;
    step(0, 0, 1, 6'd10, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 6'd0, 32'h0, 32'h0);
    chk("rstmc c3 busy", 32'(bus.busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstmc stall", 32'(bus.stall), 32'h0);
    chk("rstmc busy", 32'(bus.busy), 32'h0);
    chk("rstmc mc_cnt", 32'(dut.mc_cnt), 32'h0);
    chk("rstmc done", 32'(bus.ex_mc_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 0, 6'd0, 32'h0, 32'h0);
      any_done |= bus.ex_mc_done;
    end
    chk("rstmc no done", 32'(any_done), 32'h0);
    chk("rstmc idle busy", 32'(bus.busy), 32'h0);

    // Randomized run against a cycle-level model of remaining work and exception phase
    do_reset();
    m_rem = 0; m_phase = 0; m_done = 0; m_pc = 32'h0;
    for (int c = 0; c < 400; c++) begin
      r_id  = ($urandom_range(0, 3) == 0);
      r_mem = ($urandom_range(0, 4) == 0);
      r_st  = ($urandom_range(0, 5) == 0);
      n_len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
      r_len = 6'(n_len);
      r_exc = 32'h0;
      if ($urandom_range(0, 19) == 0)
        r_exc = ($urandom_range(0, 1) == 0) ? ERET : (32'h1 << $urandom_range(0, 5));
      r_epc = $urandom;

      x_live = (r_exc != 32'h0) && (m_phase == 0);
      if (x_live || m_phase == 1)        x_stall = 6'h3f;
      else if (m_phase == 2)             x_stall = 6'h00;
      else if (r_mem)                    x_stall = 6'h1f;
      else if (m_rem > 0 || r_st)        x_stall = 6'h0f;
      else if (r_id)                     x_stall = 6'h07;
      else                               x_stall = 6'h00;

      step(r_id, r_mem, r_st, r_len, r_exc, r_epc);
      chk($sformatf("rnd%0d stall", c), 32'(bus.stall), 32'(x_stall));
      chk($sformatf("rnd%0d flush", c), 32'(bus.flush), 32'(m_phase == 2));
      chk($sformatf("rnd%0d done", c), 32'(bus.ex_mc_done), 32'(m_done));
      chk($sformatf("rnd%0d busy", c), 32'(bus.busy), 32'((m_rem > 0) || (m_phase != 0)));
      if (m_phase == 2) chk($sformatf("rnd%0d new_pc", c), bus.new_pc, m_pc);

      m_done = 0;
      if (x_live) begin
        m_phase = 1;
        m_rem   = 0;
        m_pc    = (r_exc == ERET) ? r_epc : EVEC;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_rem > 0) begin
        if (!r_mem) begin
          m_rem--;
          if (m_rem == 0) m_done = 1;
        end
      end else if (r_st) begin
        if (n_len <= 1) m_done = 1;
        else            m_rem = n_len - 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage MIPS32 core.
- Merges stall requests from ID, EX and MEM into a per-stage stall vector driven to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences multi-cycle EX operations with an internal down-counter.
- On an exception or ERET reported by MEM, freezes the pipeline for one cycle, then issues a one-cycle flush with the redirect PC.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for every non-ERET exception.
- MC_W, 6, width of the multi-cycle length and counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- stallreq_id  in  1  ID requests a stall (load-use hazard).
- stallreq_mem  in  1  MEM data bus not ready.
- ex_mc_start  in  1  one-cycle pulse: EX begins a multi-cycle operation.
- ex_mc_len  in  MC_W  total EX cycles for the operation; 0 is treated as 1.
- excepttype  in  32  exception code from MEM stage; 0 means none.
- cp0_epc  in  32  EPC value from CP0.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold that stage's register.
- flush  out  1  clear all pipeline registers (registered output).
- new_pc  out  32  redirect target; valid only while flush=1 (registered output).
- ex_mc_done  out  1  one-cycle pulse when the multi-cycle op completes (registered output).
- busy  out  1  state != RUN.

Behaviour:
- Reset values while rst=1, asynchronous: state=RUN, mc_cnt=0, flush=0, new_pc=0, ex_mc_done=0. stall=0 follows from state RUN with no requests.
- States:
  - RUN: normal operation.
  - MC_BUSY: multi-cycle EX operation in progress.
  - EXC_HOLD: exception captured, pipeline frozen for one cycle.
  - FLUSH: flush asserted for one cycle.
- stall is combinational from state and inputs. Priority, highest first:
  - excepttype!=0 in RUN or MC_BUSY -> 6'b111111.
  - state==EXC_HOLD -> 6'b111111.
  - state==FLUSH -> 6'b000000.
  - stallreq_mem -> 6'b011111.
  - state==MC_BUSY, or ex_mc_start in RUN -> 6'b001111.
  - stallreq_id -> 6'b000111.
  - otherwise -> 6'b000000.
- RUN transitions:
  - excepttype!=0 -> EXC_HOLD. Capture new_pc = cp0_epc if excepttype==EXC_ERET, else EXC_VECTOR.
  - ex_mc_start with effective length L (ex_mc_len, or 1 if 0):
    - L==1: no state change; ex_mc_done=1 next cycle.
    - L>=2: mc_cnt <= L-1, go to MC_BUSY.
- MC_BUSY:
  - mc_cnt decrements every cycle in which stallreq_mem=0; it holds while stallreq_mem=1.
  - When mc_cnt==1 and decrementing: ex_mc_done=1 next cycle, mc_cnt becomes 0, state returns to RUN.
  - Total EX occupancy from the start pulse is L cycles plus any MEM stall cycles.
  - ex_mc_start while already in MC_BUSY is ignored.
- EXC_HOLD: unconditional -> FLUSH. flush=1 and new_pc are presented during the FLUSH cycle.
- FLUSH: unconditional -> RUN; flush returns to 0. excepttype during the FLUSH cycle is ignored (the flush kills its source).
- Exception during MC_BUSY: the operation is aborted. mc_cnt is cleared, no ex_mc_done pulse, state -> EXC_HOLD.
- Simultaneous ex_mc_start and excepttype!=0 in RUN: the exception wins and the start is discarded.
- Timing: exception seen in cycle N -> stall=all-ones in N and N+1, flush=1 in N+2, normal operation resumes in N+3.
- Reset asserted mid-operation: immediate return to reset values. No done or flush pulse is emitted.
- ex_mc_done and flush are single-cycle pulses and are never asserted in the same cycle.

Decomposition:
- Shared package/defines, alongside the existing `define.v` style:
  - EXC_ERET = 32'h0000_000e.
  - Stall vector constants STALL_NONE, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL.
  - State encodings for RUN, MC_BUSY, EXC_HOLD, FLUSH.
- One natural sub-module: mc_counter. It handles load / decrement-with-enable / done pulse, so the counter is verifiable in isolation. The FSM and stall priority mux stay in pipe_ctrl.

Test Plan:
- Reset mid-MC_BUSY: start with len=10, assert rst at cycle 4 -> same-cycle state=RUN, stall=0, mc_cnt=0; no ex_mc_done after rst release.
- Priority: stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111; then stallreq_id alone -> 6'b000111; then none -> 6'b000000.
- Multi-cycle: ex_mc_start with len=4 at cycle 0 -> stall=6'b001111 in cycles 0-3, ex_mc_done=1 in cycle 4, stall=0 in cycle 4. With len=0 -> behaves as len=1: done in cycle 1, no MC_BUSY.
- MEM stall inside MC_BUSY: len=3 with stallreq_mem=1 for 2 cycles at cycle 1 -> stall=6'b011111 in those cycles, done delayed to cycle 5.
- Exception: excepttype=32'h8 at cycle N -> stall=6'b111111 in N and N+1, flush=1 and new_pc=32'h20 in N+2, stall=0 and flush=0 in N+3. ERET with cp0_epc=32'hBFC0_0100 -> new_pc=32'hBFC0_0100.
- Abort: exception at cycle 2 of a len=8 op -> no ex_mc_done ever, flush in cycle 4, busy=0 in cycle 5.
